// File: rtl/axi_pkg.sv
// Shared AXI widths, burst and response encodings, and FSM state types
// used by the SDRAM slave memory model.
package axi_pkg;

   localparam int ID_BITS    = 4;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int LEN_BITS   = 8;
   localparam int SIZE_BITS  = 3;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   localparam logic [2:0] OKAY   = 3'b000;
   localparam logic [2:0] SLVERR = 3'b010;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/sdram_mem.sv
// Word-addressed RAM array: asynchronous read, byte-enabled synchronous write.
// Never reset, so contents preloaded through sdram_inst.ram survive reset.
module sdram_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 4096
) (
   input  logic                         clk_i,
   input  logic                         we,
   input  logic [$clog2(MEM_DEPTH)-1:0] widx,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [DATA_WIDTH/8-1:0]      wstrb,
   input  logic [$clog2(MEM_DEPTH)-1:0] ridx,
   output logic [DATA_WIDTH-1:0]        rdata
);

   logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wstrb[b]) ram[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = ram[ridx];

endmodule

// File: rtl/axi_sdram_slave.sv
// AXI4-style slave memory model with independent read and write FSMs.
// Define SDRAM_OOR_ERR_EN to flag out-of-range word indices with SLVERR.
module axi_sdram_slave #(
   parameter int ID_BITS    = axi_pkg::ID_BITS,
   parameter int ADDR_WIDTH = axi_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = axi_pkg::DATA_WIDTH,
   parameter int LEN_BITS   = axi_pkg::LEN_BITS,
   parameter int SIZE_BITS  = axi_pkg::SIZE_BITS,
   parameter int MEM_DEPTH  = 4096
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ID_BITS-1:0]      awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [LEN_BITS-1:0]     awlen,
   input  logic [SIZE_BITS-1:0]    awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_BITS-1:0]      bid,
   output logic [2:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_BITS-1:0]      arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [LEN_BITS-1:0]     arlen,
   input  logic [1:0]              arburst,
   input  logic [SIZE_BITS-1:0]    arsize,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_BITS-1:0]      rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [2:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);

   import axi_pkg::*;

   localparam int IDX_BITS = $clog2(MEM_DEPTH);

   w_state_t              w_state;
   r_state_t              r_state;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [SIZE_BITS-1:0]  wr_size, rd_size;
   logic [1:0]            wr_burst, rd_burst;
   logic [LEN_BITS-1:0]   rd_len, rd_count;
   logic                  wr_err, wr_oor, rd_oor, mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  awlen_unused;

   // The write length is not needed: wlast alone terminates a write burst.
   assign awlen_unused = ^awlen;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [SIZE_BITS-1:0]  s,
      input logic [1:0]            b
   );
      logic [ADDR_WIDTH-1:0] step;
      step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << s;
      case (b)
         FIXED:      next_addr = a;
         INCR, WRAP: next_addr = a + step;
         default:    next_addr = a + step;
      endcase
   endfunction

`ifdef SDRAM_OOR_ERR_EN
   assign wr_oor = |wr_addr[ADDR_WIDTH-1:IDX_BITS+2];
   assign rd_oor = |rd_addr[ADDR_WIDTH-1:IDX_BITS+2];
`else
   assign wr_oor = 1'b0;
   assign rd_oor = 1'b0;
`endif

   assign mem_we = (w_state == W_DATA) && wvalid && !wr_oor;
   assign rdata  = rd_oor ? '0 : mem_rdata;
   assign rresp  = (rvalid && rd_oor) ? SLVERR : OKAY;

   sdram_mem #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) sdram_inst (
      .clk_i (clk_i),
      .we    (mem_we),
      .widx  (wr_addr[IDX_BITS+1:2]),
      .wdata (wdata),
      .wstrb (wstrb),
      .ridx  (rd_addr[IDX_BITS+1:2]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         w_state <= W_IDLE;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= '0;
         bresp   <= OKAY;
         wr_err  <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (awvalid && awready) begin
                  bid      <= awid;
                  wr_addr  <= awaddr;
                  wr_size  <= awsize;
                  wr_burst <= awburst;
                  wr_err   <= 1'b0;
                  awready  <= 1'b0;
                  wready   <= 1'b1;
                  w_state  <= W_DATA;
               end else begin
                  awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (wvalid) begin
                  wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
                  wr_err  <= wr_err | wr_oor;
                  if (wlast) begin
                     wready  <= 1'b0;
                     bvalid  <= 1'b1;
                     bresp   <= (wr_err || wr_oor) ? SLVERR : OKAY;
                     w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // rlast is registered one beat ahead so it is valid alongside each beat.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         r_state <= R_IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rid     <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (arvalid && arready) begin
                  rid      <= arid;
                  rd_addr  <= araddr;
                  rd_len   <= arlen;
                  rd_size  <= arsize;
                  rd_burst <= arburst;
                  rd_count <= '0;
                  rlast    <= (arlen == '0);
                  arready  <= 1'b0;
                  rvalid   <= 1'b1;
                  r_state  <= R_DATA;
               end else begin
                  arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  rd_addr  <= next_addr(rd_addr, rd_size, rd_burst);
                  rd_count <= rd_count + LEN_BITS'(1);
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     arready <= 1'b1;
                     r_state <= R_IDLE;
                  end else begin
                     rlast <= ((rd_count + LEN_BITS'(1)) == rd_len);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sdram_slave.sv
// Self-checking bench for axi_sdram_slave: directed scenarios plus randomized
// bursts compared against a word-array reference model.
module tb_axi_sdram_slave;

   localparam int DEPTH = 4096;
`ifdef SDRAM_OOR_ERR_EN
   localparam bit OOR_EN = 1'b1;
`else
   localparam bit OOR_EN = 1'b0;
`endif

   typedef logic [31:0] word_q_t [$];
   typedef logic [3:0]  strb_q_t [$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awid = '0, arid = '0, bid, rid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [2:0]  awsize = '0, arsize = '0, bresp, rresp;
   logic [1:0]  awburst = '0, arburst = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
   logic        awready, wready, bvalid, arready, rlast, rvalid;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [DEPTH];

   always #5 clk = ~clk;

   axi_sdram_slave dut (
      .clk_i(clk), .rst_ni(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arsize(arsize),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_oor(input logic [31:0] a);
      return OOR_EN && ((a >> 2) >= DEPTH);
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      if (is_oor(a)) return 32'h0;
      return model[(a >> 2) % DEPTH];
   endfunction

   function automatic logic [2:0] exp_rresp(input logic [31:0] a);
      return is_oor(a) ? 3'b010 : 3'b000;
   endfunction

   function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
      return (bu == 2'b00) ? a : a + (32'd1 << sz);
   endfunction

   task automatic applyStimulusWrite(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] sz,
                                     input logic [1:0] bu, input logic [3:0] id, input word_q_t d,
                                     input strb_q_t s, input bit gaps);
      int t;
      logic [31:0] cur;
      bit any_oor;
      @(negedge clk);
      awvalid = 1; awaddr = addr; awlen = len; awsize = sz; awburst = bu; awid = id;
      t = 0;
      while (awready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checkOutput("awready", awready, 1);
      @(negedge clk);
      awvalid = 0;
      checkOutput("awready_busy", awready, 0);
      cur = addr;
      any_oor = 0;
      for (int b = 0; b <= int'(len); b++) begin
         if (gaps && $urandom_range(3) == 0) begin wvalid = 0; @(negedge clk); end
         checkOutput("wready", wready, 1);
         wvalid = 1; wdata = d[b]; wstrb = s[b]; wlast = (b == int'(len));
         if (is_oor(cur)) any_oor = 1;
         else begin
            for (int k = 0; k < 4; k++)
               if (s[b][k]) model[(cur >> 2) % DEPTH][8*k +: 8] = d[b][8*k +: 8];
         end
         @(negedge clk);
         cur = tb_next(cur, sz, bu);
      end
      wvalid = 0; wlast = 0;
      checkOutput("bvalid", bvalid, 1);
      checkOutput("bid", bid, id);
      checkOutput("bresp", bresp, any_oor ? 3'b010 : 3'b000);
      if (gaps && $urandom_range(1) == 1) begin
         @(negedge clk);
         checkOutput("bvalid_hold", bvalid, 1);
      end
      bready = 1;
      @(negedge clk);
      bready = 0;
      checkOutput("bvalid_clear", bvalid, 0);
   endtask

   task automatic applyStimulusRead(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] sz,
                                    input logic [1:0] bu, input logic [3:0] id, input int stall_pct);
      int t;
      int b;
      logic [31:0] cur;
      @(negedge clk);
      arvalid = 1; araddr = addr; arlen = len; arsize = sz; arburst = bu; arid = id;
      t = 0;
      while (arready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checkOutput("arready", arready, 1);
      @(negedge clk);
      arvalid = 0;
      checkOutput("arready_busy", arready, 0);
      cur = addr;
      b = 0;
      t = 0;
      while (b <= int'(len) && t < 400) begin
         checkOutput("rvalid", rvalid, 1);
         checkOutput("rdata", rdata, exp_rdata(cur));
         checkOutput("rid", rid, id);
         checkOutput("rlast", rlast, b == int'(len));
         checkOutput("rresp", rresp, exp_rresp(cur));
         rready = ($urandom_range(99) >= stall_pct);
         @(negedge clk);
         if (rready) begin b++; cur = tb_next(cur, sz, bu); end
         t++;
      end
      rready = 0;
      checkOutput("read_done", b, int'(len) + 1);
      checkOutput("rvalid_end", rvalid, 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation hung");
   end

   initial begin
      word_q_t wq;
      strb_q_t sq;
      int t;

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      checkOutput("rst_awready", awready, 0);
      checkOutput("rst_wready", wready, 0);
      checkOutput("rst_bvalid", bvalid, 0);
      checkOutput("rst_arready", arready, 0);
      checkOutput("rst_rvalid", rvalid, 0);
      checkOutput("rst_rlast", rlast, 0);
      checkOutput("rst_ids", {bid, rid}, 8'h00);
      checkOutput("rst_resps", {bresp, rresp}, 6'h00);
      rst = 0;
      @(negedge clk);
      checkOutput("post_rst_awready", awready, 1);
      checkOutput("post_rst_arready", arready, 1);

      $display("[TB] preload and INCR read burst");
      wq = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      sq = {4'hF, 4'hF, 4'hF, 4'hF};
      applyStimulusWrite(32'h0, 8'd3, 3'd2, 2'b01, 4'h2, wq, sq, 1'b0);
      applyStimulusRead(32'h0, 8'd3, 3'd2, 2'b01, 4'h5, 0);

      $display("[TB] single write then byte-masked overwrite");
      wq = {32'hDEADBEEF}; sq = {4'hF};
      applyStimulusWrite(32'h10, 8'd0, 3'd2, 2'b01, 4'h7, wq, sq, 1'b0);
      applyStimulusRead(32'h10, 8'd0, 3'd2, 2'b01, 4'h1, 0);
      wq = {32'h000000AA}; sq = {4'h1};
      applyStimulusWrite(32'h10, 8'd0, 3'd2, 2'b01, 4'h7, wq, sq, 1'b0);
      checkOutput("masked_model", model[4], 32'hDEADBEAA);
      applyStimulusRead(32'h10, 8'd0, 3'd2, 2'b01, 4'h1, 0);

      $display("[TB] FIXED read with stalls");
      applyStimulusRead(32'h4, 8'd2, 3'd2, 2'b00, 4'hA, 50);

      $display("[TB] reset during a read burst");
      @(negedge clk);
      arvalid = 1; araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'h9;
      t = 0;
      while (arready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checkOutput("mid_arready", arready, 1);
      @(negedge clk);
      arvalid = 0; rready = 1;
      checkOutput("mid_beat0", rdata, 32'h11111111);
      @(negedge clk);
      checkOutput("mid_beat1", rdata, 32'h22222222);
      rready = 0; rst = 1;
      @(negedge clk);
      checkOutput("mid_rst_rvalid", rvalid, 0);
      checkOutput("mid_rst_rlast", rlast, 0);
      checkOutput("mid_rst_arready", arready, 0);
      checkOutput("mid_rst_rid", rid, 0);
      rst = 0;
      @(negedge clk);
      checkOutput("mid_rel_arready", arready, 1);
      checkOutput("mid_rel_awready", awready, 1);
      checkOutput("mid_rel_rvalid", rvalid, 0);
      applyStimulusRead(32'h0, 8'd3, 3'd2, 2'b01, 4'h3, 0);

      $display("[TB] read beyond the array");
      applyStimulusRead(32'h4000, 8'd0, 3'd2, 2'b01, 4'h4, 0);
      if (!OOR_EN) checkOutput("wrap_model", exp_rdata(32'h4000), 32'h11111111);

      $display("[TB] randomized prefill");
      for (int blk = 0; blk < 8; blk++) begin
         wq.delete(); sq.delete();
         for (int i = 0; i < 16; i++) begin wq.push_back($urandom); sq.push_back(4'hF); end
         applyStimulusWrite(32'(blk * 64), 8'd15, 3'd2, 2'b01, 4'(blk), wq, sq, 1'b1);
      end

      $display("[TB] simultaneous write and read");
      wq.delete(); sq.delete();
      for (int i = 0; i < 4; i++) begin wq.push_back($urandom); sq.push_back(4'hF); end
      fork
         applyStimulusWrite(32'h180, 8'd3, 3'd2, 2'b01, 4'hC, wq, sq, 1'b0);
         applyStimulusRead(32'h20, 8'd3, 3'd2, 2'b01, 4'hD, 0);
      join

      $display("[TB] randomized transactions");
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         logic [7:0]  l;
         logic [2:0]  sz;
         logic [1:0]  bu;
         logic [3:0]  id;
         a  = 32'($urandom_range(63)) << 2;
         l  = 8'($urandom_range(7));
         sz = 3'($urandom_range(2));
         bu = 2'($urandom_range(3));
         id = 4'($urandom_range(15));
         if ($urandom_range(1) == 1) begin
            wq.delete(); sq.delete();
            for (int i = 0; i <= int'(l); i++) begin
               wq.push_back($urandom);
               sq.push_back(4'($urandom_range(15)));
            end
            applyStimulusWrite(a, l, sz, bu, id, wq, sq, 1'b1);
         end else begin
            applyStimulusRead(a, l, sz, bu, id, 30);
         end
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_sdram_slave.md
# axi_sdram_slave

- AXI4-style slave memory model, the clean implementation of `slave_0_sdram`.
- Serves single and burst reads and writes from the CPU master into a word-addressed RAM array.
- The array can be preloaded by simulation `$readmemh` through the hierarchical path `<inst>.sdram_inst.ram`.
- Read and write channels run independently, each with its own state machine.

## Interface
- ID_BITS, 4, width of transaction ID
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width; beat = DATA_WIDTH/8 bytes
- LEN_BITS, 8, burst length field; beats = len+1
- SIZE_BITS, 3, burst size field
- MEM_DEPTH, 4096, number of DATA_WIDTH words
- clk_i  in  1  single clock, all logic on rising edge
- rst_ni  in  1  reset: synchronous and active-high (asserted = 1); port name kept per codebase
- awid/awaddr/awlen/awsize/awburst  in  ID_BITS/ADDR_WIDTH/LEN_BITS/SIZE_BITS/2  write address
- awvalid in 1, awready out 1  AW handshake
- wdata in DATA_WIDTH, wstrb in DATA_WIDTH/8, wlast in 1  write data
- wvalid in 1, wready out 1  W handshake
- bid out ID_BITS, bresp out 3, bvalid out 1, bready in 1  write response
- arid/araddr/arlen/arburst/arsize  in  ID_BITS/ADDR_WIDTH/LEN_BITS/2/SIZE_BITS  read address
- arvalid in 1, arready out 1  AR handshake
- rid out ID_BITS, rdata out DATA_WIDTH, rresp out 3, rlast out 1  read data
- rvalid out 1, rready in 1  R handshake

## Operation
- Word index = addr[log2(MEM_DEPTH)+1:2], i.e. modulo MEM_DEPTH.
- Burst address update per beat:
  - FIXED (00): address unchanged.
  - INCR (01): address += 1<<size.
  - WRAP (10) and reserved (11): treated as INCR.
- Write FSM states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On awvalid, latch id/addr/len/size/burst and go to W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes ram[idx] byte-wise where wstrb bit is 1, then advances the address. A beat with wlast=1 goes to W_RESP. wlast is trusted; the beat count is not checked.
  - W_RESP: bvalid=1, bid = latched id, bresp = 3'b000. On bready go to W_IDLE.
- Read FSM states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid, latch id/addr/len/size/burst, clear beat count, go to R_DATA.
  - R_DATA: rvalid=1, rdata = ram[idx(cur_addr)] combinationally, rid = latched id, rresp = 3'b000, rlast = (count == len).
  - On rvalid&rready: advance the address and increment count. If rlast, go to R_IDLE.
- Same-word read and write in the same cycle: the read returns the old data; the write takes effect at the clock edge.
- The memory is not cleared by reset, so preloaded contents survive.

## Timing
- Reset outputs:
  - awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0.
  - bid=0, rid=0, bresp=0, rresp=0.
  - Both FSMs return to idle, including when reset is asserted mid-burst.
  - The cycle after reset deassertion: awready=1 and arready=1.
- AW handshake at edge N -> wready=1 from N+1.
- Last W beat at edge M -> bvalid=1 from M+1.
- AR handshake at edge N -> rvalid=1 with beat 0 from N+1.
- Subsequent beats are back-to-back (one per cycle) while rready=1. Stalled beats hold rdata, rlast and rid stable.
- awready is 0 outside W_IDLE and arready is 0 outside R_IDLE: one outstanding transaction per channel.
- Simultaneous AW and AR are both accepted in the same cycle.

## Configuration
- Macro: SDRAM_OOR_ERR_EN.
- Defined: an address whose word index is >= MEM_DEPTH (address bits above the index are nonzero) is out of range.
  - Out-of-range write beat: suppressed; bresp = 3'b010 if any beat of the burst was out of range.
  - Out-of-range read beat: rdata=0, rresp=3'b010.
- Undefined: index taken modulo MEM_DEPTH; responses always 3'b000.

## Structure
- Shared package axi_pkg:
  - Width constants ID_BITS, ADDR_WIDTH, DATA_WIDTH, LEN_BITS, SIZE_BITS.
  - Burst encodings FIXED/INCR/WRAP.
  - Response codes OKAY=3'b000, SLVERR=3'b010.
  - FSM state enums.
- One sub-module `sdram_mem`, instance name `sdram_inst`:
  - Array `ram[MEM_DEPTH]` of DATA_WIDTH.
  - Asynchronous read, byte-enabled synchronous write.

## Test plan
- Preload ram[0..3]=11111111,22222222,33333333,44444444; read araddr=0, arlen=3, arsize=2, INCR, rready=1 -> 4 consecutive beats in order, rlast only on beat 3, rid=arid.
- Write addr 0x10, len=0, wdata=DEADBEEF, wstrb=F -> bvalid next cycle after the W beat, bresp=0; then read 0x10 -> DEADBEEF.
- Write 0x10 wdata=000000AA, wstrb=0001 over DEADBEEF -> readback DEADBEAA.
- FIXED read burst len=2 at 0x4 with rready toggling -> 22222222 three times; data held stable while stalled.
- Reset asserted mid read burst -> next cycle rvalid=0, arready=1 after release; a new read starts at beat 0.
- With SDRAM_OOR_ERR_EN, read 0x4000 (MEM_DEPTH=4096) -> rresp=3'b010, rdata=0. Without it -> data of ram[0].
